// File: rtl/bnn_pkg.sv
// rtl/bnn_pkg.sv - shared widths, types and threshold entry for the BNN partial-sum binarizer
package bnn_pkg;
    localparam int PSUM_W     = 7;
    localparam int ACC_W      = 12;
    localparam int PACK_W     = 7;
    localparam int THR_DEPTH  = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int THR_AW     = $clog2(THR_DEPTH);
    localparam int PCNT_W     = $clog2(PACK_W);

    typedef logic signed [PSUM_W-1:0] psum_t;
    typedef logic signed [ACC_W-1:0]  acc_t;
    typedef logic [PACK_W-1:0]        act_word_t;

    typedef struct packed {
        acc_t thr;
        logic flip;
    } thr_entry_t;

    localparam acc_t ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam acc_t ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
endpackage

// File: rtl/bnn_sync_fifo.sv
// rtl/bnn_sync_fifo.sv - small synchronous valid/ready FIFO with full flag, pop-first when full
module bnn_sync_fifo #(
    parameter int W     = 7,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_full,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_valid = (r_count != '0);
    assign o_data  = r_mem[r_rd_ptr];
    assign w_pop   = o_valid & i_ready;
    assign w_push  = i_valid & (~o_full | w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/bnn_psum_binarizer.sv
// rtl/bnn_psum_binarizer.sv - accumulate partial sums, threshold to 1-bit, pack to words, queue out
// Optional BNN_ACC_SAT_EN: saturating accumulator with sticky sat_flag (default wraps, sat_flag=0).
module bnn_psum_binarizer
    import bnn_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  psum_t             in_psum,
    input  logic              in_last,
    input  logic [THR_AW-1:0] in_och,
    input  logic              thr_wr_en,
    input  logic [THR_AW-1:0] thr_wr_addr,
    input  acc_t              thr_wr_data,
    input  logic              thr_wr_flip,
    output logic              out_valid,
    input  logic              out_ready,
    output act_word_t         out_bits,
    output logic              sat_flag
);
    thr_entry_t         r_thr [THR_DEPTH];
    acc_t               r_acc;
    logic [PCNT_W-1:0]  r_pack_cnt;
    act_word_t          r_pack_reg;

    logic       w_beat;
    logic       w_full;
    acc_t       w_acc_next;
    logic       w_clamp;
    thr_entry_t w_entry;
    logic       w_bit;
    act_word_t  w_word;
    logic       w_push;

    assign in_ready = ~w_full;
    assign w_beat   = in_valid & in_ready;

`ifdef BNN_ACC_SAT_EN
    logic signed [ACC_W:0] w_sum;
    logic                  r_sat;

    assign w_sum   = {r_acc[ACC_W-1], r_acc} + {{(ACC_W+1-PSUM_W){in_psum[PSUM_W-1]}}, in_psum};
    assign w_clamp = w_sum[ACC_W] ^ w_sum[ACC_W-1];

    always_comb begin
        w_acc_next = w_sum[ACC_W-1:0];
        if (w_clamp) w_acc_next = w_sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end

    always_ff @(posedge clk) begin
        if (rst)                 r_sat <= 1'b0;
        else if (w_beat & w_clamp) r_sat <= 1'b1;
    end
    assign sat_flag = r_sat;
`else
    assign w_acc_next = r_acc + acc_t'(in_psum);
    assign w_clamp    = 1'b0;
    assign sat_flag   = w_clamp;
`endif

    // Table read is combinational, so a same-cycle write is seen only from the next edge on.
    assign w_entry = r_thr[in_och];
    assign w_bit   = ($signed(w_acc_next) >= $signed(w_entry.thr)) ^ w_entry.flip;
    assign w_word  = r_pack_reg | (act_word_t'(w_bit) << r_pack_cnt);
    assign w_push  = w_beat & in_last & (r_pack_cnt == PCNT_W'(PACK_W-1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc      <= '0;
            r_pack_cnt <= '0;
            r_pack_reg <= '0;
            for (int i = 0; i < THR_DEPTH; i++) r_thr[i] <= '0;
        end else begin
            if (thr_wr_en) r_thr[thr_wr_addr] <= '{thr: thr_wr_data, flip: thr_wr_flip};
            if (w_beat) begin
                if (in_last) begin
                    r_acc <= '0;
                    if (w_push) begin
                        r_pack_cnt <= '0;
                        r_pack_reg <= '0;
                    end else begin
                        r_pack_cnt <= r_pack_cnt + 1'b1;
                        r_pack_reg <= w_word;
                    end
                end else begin
                    r_acc <= w_acc_next;
                end
            end
        end
    end

    bnn_sync_fifo #(
        .W     (PACK_W),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_push),
        .i_data  (w_word),
        .o_full  (w_full),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (out_bits)
    );
endmodule
